// File: rtl/irq_controller_pkg.sv
// irq_controller shared package
// FSM states, id width and default sizing.
package irq_controller_pkg;

    localparam int IRQ_ID_W    = 4;
    localparam int N_SRC_DEF   = 8;
    localparam int HOLDOFF_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_HOLD = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_controller_if.sv
// irq_controller bus interface
// Request lines, software writes and processor-facing outputs.
interface irq_controller_if #(
    parameter int N_SRC = 8
) ();
    import irq_controller_pkg::*;

    logic [N_SRC-1:0]    irq_req;
    logic                mask_wr_en;
    logic                clr_wr_en;
    logic [15:0]         wr_data;
    logic                interrupt;
    logic [IRQ_ID_W-1:0] irq_id;
    logic [15:0]         cause;
    logic                busy;

    modport master (
        output irq_req, mask_wr_en, clr_wr_en, wr_data,
        input  interrupt, irq_id, cause, busy
    );

    modport slave (
        input  irq_req, mask_wr_en, clr_wr_en, wr_data,
        output interrupt, irq_id, cause, busy
    );
endinterface

// File: rtl/irq_controller_sync_edge.sv
// irq_sync_edge: one request line
// 2-FF synchroniser followed by a rising-edge detector.
module irq_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);
    logic s1, s2, s2_d;

    // Two metastability stages plus the previous-sample register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
        end else begin
            s1   <= d;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    assign rise = s2 & ~s2_d;
endmodule

// File: rtl/irq_controller.sv
// irq_controller: prioritised interrupt pulser
// Pending/mask registers, priority encoder and FIRE/HOLD sequencer.
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int N_SRC   = N_SRC_DEF,
    parameter int HOLDOFF = HOLDOFF_DEF
) (
    input  logic             clk,
    input  logic             reset,
    irq_controller_if.slave  bus
);
    localparam int CNT_W = $clog2(HOLDOFF) + 1;

    irq_state_t          state;
    logic [CNT_W-1:0]    cnt;
    logic [N_SRC-1:0]    rise;
    logic [N_SRC-1:0]    pending, mask;
    logic [N_SRC-1:0]    pend_nxt, mask_nxt;
    logic [N_SRC-1:0]    req, fire_clr;
    logic [IRQ_ID_W-1:0] win;
    logic [15:0]         cause_nxt;
    logic                unused_wr;

    assign unused_wr = ^(bus.wr_data >> N_SRC);

    for (genvar g = 0; g < N_SRC; g++) begin : g_sync
        irq_sync_edge u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (bus.irq_req[g]),
            .rise  (rise[g])
        );
    end

    assign req = pending & mask;

    // Lowest enabled index wins; scan downward so the last hit is lowest.
    always_comb begin
        win = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) win = IRQ_ID_W'(i);
        end
    end

    // Next-state pending/mask; a new edge beats any clear of that bit.
    always_comb begin
        fire_clr = '0;
        if (state == ST_IDLE && |req) fire_clr[win] = 1'b1;
        mask_nxt = bus.mask_wr_en ? bus.wr_data[N_SRC-1:0] : mask;
        pend_nxt = pending & ~fire_clr;
        if (bus.clr_wr_en) pend_nxt = pend_nxt & ~bus.wr_data[N_SRC-1:0];
        pend_nxt = pend_nxt | rise;
        cause_nxt = '0;
        cause_nxt[N_SRC-1:0] = pend_nxt & mask_nxt;
    end

    // Pending, mask and the registered cause view.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending   <= '0;
            mask      <= '0;
            bus.cause <= '0;
        end else begin
            pending   <= pend_nxt;
            mask      <= mask_nxt;
            bus.cause <= cause_nxt;
        end
    end

    // Sequencer: IDLE picks a winner, FIRE pulses, HOLD spaces pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            bus.interrupt <= 1'b0;
            bus.busy      <= 1'b0;
            bus.irq_id    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (|req) begin
                        bus.irq_id    <= win;
                        bus.interrupt <= 1'b1;
                        bus.busy      <= 1'b1;
                        state         <= ST_FIRE;
                    end
                end
                ST_FIRE: begin
                    bus.interrupt <= 1'b0;
                    cnt           <= CNT_W'(HOLDOFF - 1);
                    state         <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        bus.busy <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed bench
// Drives on falling edges, samples on falling edges.
module tb_irq_controller;
    import irq_controller_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    irq_controller_if #(.N_SRC(8)) bus ();

    irq_controller #(.N_SRC(8), .HOLDOFF(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic wait_pulse(input int max, output int n);
        n = -1;
        for (int k = 1; k <= max; k++) begin
            @(negedge clk);
            if (bus.interrupt === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic wr_mask(input logic [15:0] v);
        bus.mask_wr_en = 1'b1;
        bus.wr_data    = v;
        @(negedge clk);
        bus.mask_wr_en = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_int"},   32'(bus.interrupt), 0);
        chk({tag, "_busy"},  32'(bus.busy),      0);
        chk({tag, "_id"},    32'(bus.irq_id),    0);
        chk({tag, "_cause"}, 32'(bus.cause),     0);
    endtask

    int n;
    int pulses;

    initial begin
        bus.irq_req    = '0;
        bus.mask_wr_en = 1'b0;
        bus.clr_wr_en  = 1'b0;
        bus.wr_data    = '0;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        reset = 1'b1;
        @(negedge clk);

        // single source, 3-cycle request
        wr_mask(16'h00FF);
        bus.irq_req[3] = 1'b1;
        repeat (3) @(negedge clk);
        bus.irq_req[3] = 1'b0;
        wait_pulse(10, n);
        chk("t1_lat", 32'(n + 3), 4);
        chk("t1_id", 32'(bus.irq_id), 3);
        chk("t1_busy", 32'(bus.busy), 1);
        @(negedge clk);
        chk("t1_width", 32'(bus.interrupt), 0);
        chk("t1_cause", 32'(bus.cause), 0);
        repeat (25) @(negedge clk);

        // two simultaneous edges, priority and spacing
        bus.irq_req[5] = 1'b1;
        bus.irq_req[2] = 1'b1;
        wait_pulse(10, n);
        chk("t2_lat", 32'(n), 4);
        chk("t2_id0", 32'(bus.irq_id), 2);
        chk("t2_cause", 32'(bus.cause), 32'h20);
        wait_pulse(30, n);
        chk("t2_gap", 32'(n), 18);
        chk("t2_id1", 32'(bus.irq_id), 5);
        bus.irq_req = '0;
        repeat (25) @(negedge clk);

        // masked source accumulates, fires once unmasked
        wr_mask(16'h0000);
        bus.irq_req[1] = 1'b1;
        wait_pulse(12, n);
        chk("t3_nopulse", 32'(n), 32'hFFFF_FFFF);
        chk("t3_cause0", 32'(bus.cause), 0);
        bus.mask_wr_en = 1'b1;
        bus.wr_data    = 16'h0002;
        @(negedge clk);
        bus.mask_wr_en = 1'b0;
        chk("t3_cause2", 32'(bus.cause), 2);
        wait_pulse(5, n);
        chk("t3_lat", 32'(n), 1);
        chk("t3_id", 32'(bus.irq_id), 1);
        chk("t3_cause_after", 32'(bus.cause), 0);
        bus.irq_req[1] = 1'b0;
        repeat (25) @(negedge clk);

        // software clear of a masked pending bit
        wr_mask(16'h0000);
        bus.irq_req[4] = 1'b1;
        repeat (4) @(negedge clk);
        chk("t4_cause0", 32'(bus.cause), 0);
        bus.clr_wr_en = 1'b1;
        bus.wr_data   = 16'h0010;
        @(negedge clk);
        bus.clr_wr_en = 1'b0;
        wr_mask(16'h0010);
        wait_pulse(12, n);
        chk("t4_cleared", 32'(n), 32'hFFFF_FFFF);
        chk("t4_cause1", 32'(bus.cause), 0);

        // clear colliding with a fresh edge: edge wins
        wr_mask(16'h0000);
        bus.irq_req[4] = 1'b0;
        repeat (4) @(negedge clk);
        bus.irq_req[4] = 1'b1;
        repeat (2) @(negedge clk);
        bus.clr_wr_en = 1'b1;
        bus.wr_data   = 16'h0010;
        @(negedge clk);
        bus.clr_wr_en = 1'b0;
        bus.mask_wr_en = 1'b1;
        bus.wr_data    = 16'h0010;
        @(negedge clk);
        bus.mask_wr_en = 1'b0;
        chk("t4_setwins", 32'(bus.cause), 32'h10);
        wait_pulse(5, n);
        chk("t4_lat", 32'(n), 1);
        chk("t4_id", 32'(bus.irq_id), 4);
        bus.irq_req[4] = 1'b0;
        repeat (25) @(negedge clk);

        // a held level requests once
        wr_mask(16'h0001);
        bus.irq_req[0] = 1'b1;
        pulses = 0;
        repeat (100) begin
            @(negedge clk);
            pulses += int'(bus.interrupt);
        end
        bus.irq_req[0] = 1'b0;
        repeat (30) begin
            @(negedge clk);
            pulses += int'(bus.interrupt);
        end
        chk("t5_pulses", 32'(pulses), 1);

        // reset during FIRE
        wr_mask(16'h00FF);
        bus.irq_req[7:6] = 2'b11;
        wait_pulse(10, n);
        chk("t6_lat", 32'(n), 4);
        chk("t6_id", 32'(bus.irq_id), 6);
        chk("t6_cause", 32'(bus.cause), 32'h80);
        bus.irq_req = '0;
        #1 reset = 1'b0;
        #1 chk_zero("t6_fire");
        @(negedge clk);
        reset = 1'b1;
        wr_mask(16'h00FF);
        wait_pulse(15, n);
        chk("t6_nopulse_a", 32'(n), 32'hFFFF_FFFF);

        // reset during HOLD
        bus.irq_req[7:6] = 2'b11;
        wait_pulse(10, n);
        chk("t6_lat_b", 32'(n), 4);
        repeat (5) @(negedge clk);
        chk("t6_hold_busy", 32'(bus.busy), 1);
        chk("t6_hold_cause", 32'(bus.cause), 32'h80);
        bus.irq_req = '0;
        #1 reset = 1'b0;
        #1 chk_zero("t6_hold");
        @(negedge clk);
        reset = 1'b1;
        wr_mask(16'h00FF);
        wait_pulse(15, n);
        chk("t6_nopulse_b", 32'(n), 32'hFFFF_FFFF);

        // new edge after reset still serviced
        bus.irq_req[2] = 1'b1;
        wait_pulse(10, n);
        chk("t6_new_lat", 32'(n), 4);
        chk("t6_new_id", 32'(bus.irq_id), 2);
        bus.irq_req = '0;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
